// File: rtl/osc_pkg.sv
// Shared encodings for the oscilloscope capture path: sampling modes,
// trigger edge select and capture FSM state codes.
package osc_pkg;

    localparam logic [1:0] GATHER_IDLE   = 2'b00;
    localparam logic [1:0] GATHER_CONT   = 2'b01;
    localparam logic [1:0] GATHER_SINGLE = 2'b10;

    localparam logic TRIG_RISE = 1'b0;
    localparam logic TRIG_FALL = 1'b1;

    localparam logic [2:0] CAP_IDLE      = 3'd0;
    localparam logic [2:0] CAP_ARM       = 3'd1;
    localparam logic [2:0] CAP_WAIT_TRIG = 3'd2;
    localparam logic [2:0] CAP_POST      = 3'd3;
    localparam logic [2:0] CAP_DONE      = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = CAP_IDLE,
        ST_ARM       = CAP_ARM,
        ST_WAIT_TRIG = CAP_WAIT_TRIG,
        ST_POST      = CAP_POST,
        ST_DONE      = CAP_DONE
    } cap_state_e;

    // 11 is reserved and behaves like idle, so only 01 and 10 enable capture
    function automatic logic gather_active(input logic [1:0] g);
        return (g == GATHER_CONT) || (g == GATHER_SINGLE);
    endfunction

endpackage

// File: rtl/trigger_capture_level_cross_detect.sv
// Combinational level-crossing detector: flags the sample that reaches the
// threshold coming from the far side, on the selected edge.
module level_cross_detect
    import osc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] prev,
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] lvl,
    input  logic              edge_sel,
    input  logic              prev_valid,
    output logic              hit
);

    logic rise_hit;
    logic fall_hit;

    // Unsigned compares; no history means no crossing
    always_comb begin
        rise_hit = (prev < lvl) && (cur >= lvl);
        fall_hit = (prev > lvl) && (cur <= lvl);
        hit      = prev_valid && ((edge_sel == TRIG_FALL) ? fall_hit : rise_hit);
    end

endmodule

// File: rtl/trigger_capture.sv
// Trigger capture engine: arms on a sampling mode, fills a circular sample
// RAM with pre-trigger history, waits for a level crossing and records the
// post-trigger tail, then presents the frame start to the readout stage.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE  (0) | not sampling; pointer and last frame_start held
// ARM   (1) | writing until PRE_TRIG samples of history exist
// WAIT  (2) | writing circularly, looking for a crossing
// POST  (3) | writing the remaining DEPTH-PRE_TRIG-1 samples
// DONE  (4) | frame complete; waits for readout / mode change
module trigger_capture
    import osc_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 10,
    parameter int PRE_TRIG = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic [1:0]        gather_set,
    input  logic              trigger_set,
    input  logic [DATA_W-1:0] trigger_level,
    input  logic              rd_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_ready,
    output logic [ADDR_W-1:0] frame_start,
    output logic [2:0]        cap_state
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PRE_TRIG_A = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] PRE_LAST   = ADDR_W'(PRE_TRIG - 1);
    // Crossing sample is written in WAIT; this many more follow in POST
    localparam logic [ADDR_W-1:0] POST_LOAD  = ADDR_W'(DEPTH - PRE_TRIG - 1);

    cap_state_e        state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] pre_cnt_q;
    logic [ADDR_W-1:0] post_cnt_q;
    logic [ADDR_W-1:0] trig_addr_q;
    logic [DATA_W-1:0] prev_q;
    logic              prev_valid_q;
    logic [DATA_W-1:0] lvl_q;
    logic              edge_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              frame_ready_q;
    logic [ADDR_W-1:0] frame_start_q;

    logic              active_d;
    logic              sample_wr_d;
    logic [ADDR_W-1:0] ptr_d;
    logic              hit;

    level_cross_detect #(
        .DATA_W (DATA_W)
    ) u_cross (
        .prev       (prev_q),
        .cur        (adc_data),
        .lvl        (lvl_q),
        .edge_sel   (edge_q),
        .prev_valid (prev_valid_q),
        .hit        (hit)
    );

    // Decide whether this cycle's sample goes to RAM; POST stops writing
    // once its down-counter has reached terminal count
    always_comb begin
        active_d    = gather_active(gather_set);
        sample_wr_d = 1'b0;
        if (active_d && adc_valid) begin
            unique case (state_q)
                ST_ARM, ST_WAIT_TRIG: sample_wr_d = 1'b1;
                ST_POST:              sample_wr_d = (post_cnt_q != '0);
                default:              sample_wr_d = 1'b0;
            endcase
        end
        ptr_d = ptr_q + 1'b1;
    end

    // Capture FSM with registered write port and frame status
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            pre_cnt_q     <= '0;
            post_cnt_q    <= '0;
            trig_addr_q   <= '0;
            prev_q        <= '0;
            prev_valid_q  <= 1'b0;
            lvl_q         <= '0;
            edge_q        <= TRIG_RISE;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_ready_q <= 1'b0;
            frame_start_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (!active_d) begin
                // Soft stop: like reset but pointer and frame_start survive
                state_q       <= ST_IDLE;
                pre_cnt_q     <= '0;
                post_cnt_q    <= '0;
                trig_addr_q   <= '0;
                prev_q        <= '0;
                prev_valid_q  <= 1'b0;
                frame_ready_q <= 1'b0;
            end else begin
                if (sample_wr_d) begin
                    wr_en_q      <= 1'b1;
                    wr_addr_q    <= ptr_q;
                    wr_data_q    <= adc_data;
                    ptr_q        <= ptr_d;
                    prev_q       <= adc_data;
                    prev_valid_q <= 1'b1;
                end
                unique case (state_q)
                    ST_IDLE: begin
                        state_q      <= ST_ARM;
                        lvl_q        <= trigger_level;
                        edge_q       <= trigger_set;
                        pre_cnt_q    <= '0;
                        prev_valid_q <= 1'b0;
                    end
                    ST_ARM: begin
                        // A crossing on the completing sample is ignored;
                        // detection starts with the next one
                        if (adc_valid) begin
                            pre_cnt_q <= pre_cnt_q + 1'b1;
                            if (pre_cnt_q == PRE_LAST) begin
                                state_q <= ST_WAIT_TRIG;
                            end
                        end
                    end
                    ST_WAIT_TRIG: begin
                        if (adc_valid && hit) begin
                            trig_addr_q <= ptr_q;
                            post_cnt_q  <= POST_LOAD;
                            state_q     <= ST_POST;
                        end
                    end
                    ST_POST: begin
                        if (post_cnt_q == '0) begin
                            state_q       <= ST_DONE;
                            frame_ready_q <= 1'b1;
                            frame_start_q <= trig_addr_q - PRE_TRIG_A;
                        end else if (adc_valid) begin
                            post_cnt_q <= post_cnt_q - 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (rd_done) begin
                            frame_ready_q <= 1'b0;
                            if (gather_set == GATHER_CONT) begin
                                state_q      <= ST_ARM;
                                lvl_q        <= trigger_level;
                                edge_q       <= trigger_set;
                                pre_cnt_q    <= '0;
                                prev_valid_q <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_ready = frame_ready_q;
    assign frame_start = frame_start_q;
    assign cap_state   = state_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Bench for trigger_capture: random stimulus checked against a sample-index
// model of the capture (history length, first eligible crossing, frame span).
module tb_trigger_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] adc_data;
    logic       adc_valid;
    logic [1:0] gather_set;
    logic       trigger_set;
    logic [7:0] trigger_level;
    logic       rd_done;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_ready;
    logic [9:0] frame_start;
    logic [2:0] cap_state;

    int checks = 0;
    int fails  = 0;

    logic [7:0] samples [4096];
    logic [7:0] tb_ram  [1024];
    int         tb_ptr  = 0;
    logic [9:0] last_fs = '0;

    trigger_capture dut (
        .clk           (clk),
        .rst           (rst),
        .adc_data      (adc_data),
        .adc_valid     (adc_valid),
        .gather_set    (gather_set),
        .trigger_set   (trigger_set),
        .trigger_level (trigger_level),
        .rd_done       (rd_done),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .frame_ready   (frame_ready),
        .frame_start   (frame_start),
        .cap_state     (cap_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) tb_ram[wr_addr] <= wr_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // First crossing at sample index >= 256 (256 history samples precede it)
    function automatic int find_trigger(input bit fall, input logic [7:0] lvl, input int n);
        for (int i = 256; i < n; i++) begin
            if (fall ? (samples[i-1] > lvl && samples[i] <= lvl)
                     : (samples[i-1] < lvl && samples[i] >= lvl)) return i;
        end
        return -1;
    endfunction

    task automatic arm(input logic [1:0] mode, input bit fall, input logic [7:0] lvl);
        gather_set    = mode;
        trigger_set   = fall;
        trigger_level = lvl;
        adc_valid     = 1'b0;
        rd_done       = 1'b0;
        step();
        checks++;
        if (cap_state !== 3'd1) begin
            fails++; $display("FAIL arm_state: got %0d want 1", cap_state);
        end
    endtask

    task automatic go_idle();
        gather_set = 2'b00;
        adc_valid  = 1'b0;
        step();
        checks++;
        if (cap_state !== 3'd0 || frame_ready !== 1'b0 || wr_en !== 1'b0) begin
            fails++; $display("FAIL go_idle: state=%0d fr=%b we=%b want 0/0/0", cap_state, frame_ready, wr_en);
        end
    endtask

    // Drive samples[0..] after arming and check every cycle against the model.
    // tidx < 0 means no trigger expected.
    task automatic feed(input int n_feed, input int tidx, input bit gaps);
        int  idx = 0;
        int  cap = 0;
        int  last = (tidx >= 0) ? tidx + 767 : -1;
        bit  last_captured = 0;
        bit  in_done = 0;
        int  done_cnt = 0;
        int  cycles = 0;
        bit  v;
        bit  exp_we;
        logic [9:0] exp_addr;
        logic [7:0] exp_data;
        logic [2:0] exp_state;
        while (idx < n_feed && done_cnt < 3 && cycles < 20000) begin
            v = gaps ? ($urandom_range(3) != 0) : 1'b1;
            adc_valid = v;
            adc_data  = v ? samples[idx] : 8'($urandom);
            // mid-capture changes must have no effect
            trigger_level = 8'($urandom);
            trigger_set   = 1'($urandom);
            step();
            cycles++;
            exp_we = 0; exp_addr = '0; exp_data = '0;
            if (in_done) begin
                done_cnt++;
            end else if (last_captured) begin
                in_done = 1;
            end else if (v) begin
                exp_we   = 1;
                exp_addr = 10'(tb_ptr);
                exp_data = samples[idx];
                tb_ptr   = (tb_ptr + 1) % 1024;
                cap++;
                if (idx == last) last_captured = 1;
            end
            if (v) idx++;
            exp_state = in_done ? 3'd4 : (cap < 256) ? 3'd1 :
                        (tidx < 0 || cap <= tidx) ? 3'd2 : 3'd3;
            checks++;
            if (wr_en !== exp_we) begin
                fails++; if (fails < 40) $display("FAIL wr_en: got %b want %b (idx %0d)", wr_en, exp_we, idx);
            end
            if (exp_we) begin
                checks++;
                if (wr_addr !== exp_addr || wr_data !== exp_data) begin
                    fails++; if (fails < 40) $display("FAIL wr_port: got %0d/%h want %0d/%h", wr_addr, wr_data, exp_addr, exp_data);
                end
            end
            checks++;
            if (cap_state !== exp_state || frame_ready !== in_done) begin
                fails++; if (fails < 40) $display("FAIL cap_state: got %0d fr=%b want %0d fr=%b (cap %0d)", cap_state, frame_ready, exp_state, in_done, cap);
            end
        end
        adc_valid = 1'b0;
        if (tidx >= 0 && idx < n_feed) begin
            checks++;
            if (!in_done) begin
                fails++; $display("FAIL feed_timeout: frame not completed within budget");
            end
        end
    endtask

    task automatic check_frame(input int tidx, input int base);
        logic [9:0] fs;
        int bad = 0;
        fs = 10'((base + tidx - 256) % 1024);
        checks++;
        if (frame_start !== fs) begin
            fails++; $display("FAIL frame_start: got %0d want %0d", frame_start, fs);
        end
        for (int k = 0; k < 1024; k++) begin
            if (tb_ram[10'((fs + k) % 1024)] !== samples[tidx - 256 + k]) bad++;
        end
        checks++;
        if (bad != 0) begin
            fails++; $display("FAIL frame_content: %0d bad words, want 0", bad);
        end
        checks++;
        if (tb_ram[10'((fs + 256) % 1024)] !== samples[tidx]) begin
            fails++; $display("FAIL trig_word: got %h want %h", tb_ram[10'((fs + 256) % 1024)], samples[tidx]);
        end
        last_fs = fs;
    endtask

    task automatic test_reset();
        rst = 1'b1; gather_set = 2'b01; adc_valid = 1'b0; adc_data = 8'h00;
        trigger_set = 1'b0; trigger_level = 8'h00; rd_done = 1'b0;
        step(); step();
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== 10'd0 || wr_data !== 8'd0) begin
            fails++; $display("FAIL reset_wr: got %b/%0d/%h want 0/0/0", wr_en, wr_addr, wr_data);
        end
        checks++;
        if (frame_ready !== 1'b0 || frame_start !== 10'd0 || cap_state !== 3'd0) begin
            fails++; $display("FAIL reset_status: got %b/%0d/%0d want 0/0/0", frame_ready, frame_start, cap_state);
        end
        rst = 1'b0;
        step();
        checks++;
        if (cap_state !== 3'd1) begin
            fails++; $display("FAIL reset_release: got %0d want 1", cap_state);
        end
        go_idle();
        tb_ptr = 0;
    endtask

    task automatic test_rising();
        int tidx, base;
        for (int i = 0; i < 4096; i++) samples[i] = 8'(i % 256);
        arm(2'b01, 1'b0, 8'h55);
        tidx = find_trigger(1'b0, 8'h55, 4096);
        base = tb_ptr;
        feed(tidx + 820, tidx, 1'b1);
        check_frame(tidx, base);
        checks++;
        if (tb_ram[10'((last_fs + 256) % 1024)] !== 8'h55) begin
            fails++; $display("FAIL rise_word: got %h want 55", tb_ram[10'((last_fs + 256) % 1024)]);
        end
    endtask

    task automatic test_continuous();
        int tidx, base;
        bit fall;
        logic [7:0] lvl;
        fall = 1'($urandom);
        lvl  = 8'($urandom_range(16, 239));
        trigger_set = fall; trigger_level = lvl;
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        checks++;
        if (cap_state !== 3'd1 || frame_ready !== 1'b0) begin
            fails++; $display("FAIL cont_rearm: got %0d fr=%b want 1 fr=0", cap_state, frame_ready);
        end
        for (int i = 0; i < 4096; i++) samples[i] = 8'($urandom);
        tidx = find_trigger(fall, lvl, 3000);
        base = tb_ptr;
        feed(tidx + 820, tidx, 1'b1);
        check_frame(tidx, base);
        go_idle();
        checks++;
        if (frame_start !== last_fs) begin
            fails++; $display("FAIL idle_fs_hold: got %0d want %0d", frame_start, last_fs);
        end
    endtask

    task automatic test_falling_single();
        int tidx, base;
        for (int i = 0; i < 4096; i++) samples[i] = 8'(255 - (i % 256));
        arm(2'b10, 1'b1, 8'h30);
        tidx = find_trigger(1'b1, 8'h30, 4096);
        base = tb_ptr;
        feed(tidx + 820, tidx, 1'b0);
        check_frame(tidx, base);
        checks++;
        if (samples[tidx] !== 8'h30) begin
            fails++; $display("FAIL fall_model: got %h want 30", samples[tidx]);
        end
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        checks++;
        if (frame_ready !== 1'b0 || cap_state !== 3'd4) begin
            fails++; $display("FAIL single_rd: fr=%b state=%0d want 0/4", frame_ready, cap_state);
        end
        for (int c = 0; c < 5; c++) begin
            adc_valid = 1'b1; adc_data = 8'($urandom);
            step();
            checks++;
            if (wr_en !== 1'b0 || cap_state !== 3'd4) begin
                fails++; $display("FAIL single_hold: we=%b state=%0d want 0/4", wr_en, cap_state);
            end
        end
        go_idle();
        arm(2'b10, 1'b0, 8'h40);
        go_idle();
    endtask

    task automatic test_prefill_guard();
        int tidx, base;
        for (int i = 0; i < 4096; i++) samples[i] = 8'($urandom_range(0, 127));
        samples[9] = 8'h10;  samples[10] = 8'h90;
        samples[254] = 8'h10; samples[255] = 8'hC0; samples[256] = 8'hC0;
        samples[399] = 8'h20; samples[400] = 8'hA0;
        arm(2'b01, 1'b0, 8'h80);
        tidx = find_trigger(1'b0, 8'h80, 4096);
        base = tb_ptr;
        feed(tidx + 820, tidx, 1'b1);
        check_frame(tidx, base);
        checks++;
        if (frame_start !== 10'((base + 400 - 256) % 1024)) begin
            fails++; $display("FAIL guard_trig: got %0d want %0d", frame_start, 10'((base + 400 - 256) % 1024));
        end
        go_idle();
    endtask

    task automatic test_never_trigger();
        for (int i = 0; i < 4096; i++) samples[i] = 8'((8'h31 + i > 255) ? 255 : 8'h31 + i);
        arm(2'b01, 1'b1, 8'h30);
        feed(700, -1, 1'b1);
        checks++;
        if (cap_state !== 3'd2 || frame_ready !== 1'b0) begin
            fails++; $display("FAIL never_trig: state=%0d fr=%b want 2/0", cap_state, frame_ready);
        end
        go_idle();
    endtask

    task automatic test_abort_post();
        int tidx;
        for (int i = 0; i < 4096; i++) samples[i] = 8'(i % 256);
        arm(2'b01, 1'b0, 8'h55);
        tidx = find_trigger(1'b0, 8'h55, 4096);
        feed(tidx + 200, tidx, 1'b0);
        checks++;
        if (cap_state !== 3'd3) begin
            fails++; $display("FAIL abort_pre: state=%0d want 3", cap_state);
        end
        gather_set = 2'b00; adc_valid = 1'b1; adc_data = 8'h77;
        step();
        adc_valid = 1'b0;
        checks++;
        if (cap_state !== 3'd0 || frame_ready !== 1'b0 || wr_en !== 1'b0) begin
            fails++; $display("FAIL abort_post: state=%0d fr=%b we=%b want 0/0/0", cap_state, frame_ready, wr_en);
        end
        checks++;
        if (frame_start !== last_fs) begin
            fails++; $display("FAIL abort_fs_hold: got %0d want %0d", frame_start, last_fs);
        end
    endtask

    task automatic test_back_to_back();
        int tidx, base;
        bit fall;
        logic [7:0] lvl;
        fall = 1'($urandom);
        lvl  = 8'($urandom_range(16, 239));
        for (int i = 0; i < 4096; i++) samples[i] = 8'($urandom);
        arm(2'b11 ^ 2'b10, fall, lvl);
        tidx = find_trigger(fall, lvl, 3000);
        base = tb_ptr;
        feed(tidx + 820, tidx, 1'b1);
        check_frame(tidx, base);
        go_idle();
    endtask

    initial begin
        test_reset();
        test_rising();
        test_continuous();
        test_falling_single();
        test_prefill_guard();
        test_never_trigger();
        test_abort_post();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
